// File: rtl/dsp_mem_arbiter.sv
// dsp_mem_arbiter: shares one single-port RAM between the SPI host path and the DSP read sweep.
// DSP has priority, a starvation guard forces host slots, and a tag pipe steers read returns.
module dsp_mem_arbiter #(
    parameter int WORD_WIDTH   = 36,
    parameter int ADDR_WIDTH   = 10,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [WORD_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [WORD_WIDTH-1:0] host_rdata,
    input  logic                  dsp_req,
    input  logic [ADDR_WIDTH-1:0] dsp_addr,
    output logic                  dsp_gnt,
    output logic                  dsp_rvalid,
    output logic [WORD_WIDTH-1:0] dsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  mem_wren,
    input  logic [WORD_WIDTH-1:0] mem_q
);
    localparam logic [0:0] NORMAL     = 1'b0;
    localparam logic [0:0] FORCE_HOST = 1'b1;
    localparam logic [1:0] TAG_NONE   = 2'b00;
    localparam logic [1:0] TAG_HOST   = 2'b01;
    localparam logic [1:0] TAG_DSP    = 2'b10;

    logic [0:0]                 state;
    logic [7:0]                 starve_cnt;
    logic [ADDR_WIDTH-1:0]      addr_hold;
    logic [WORD_WIDTH-1:0]      wdata_hold;
    logic [RD_LATENCY-1:0][1:0] tag;
    logic [1:0]                 tag_in;

    // Grants are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        host_gnt  = !reset && host_req && (state == FORCE_HOST || !dsp_req);
        dsp_gnt   = !reset && dsp_req && !host_gnt;
        mem_wren  = host_gnt && host_we;
        mem_addr  = host_gnt ? host_addr : dsp_gnt ? dsp_addr : addr_hold;
        mem_wdata = host_gnt ? host_wdata : wdata_hold;
        tag_in    = (host_gnt && !host_we) ? TAG_HOST : dsp_gnt ? TAG_DSP : TAG_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= NORMAL;
            starve_cnt  <= '0;
            addr_hold   <= '0;
            wdata_hold  <= '0;
            tag         <= '0;
            host_rvalid <= 1'b0;
            dsp_rvalid  <= 1'b0;
            host_rdata  <= '0;
            dsp_rdata   <= '0;
        end else begin
            addr_hold   <= mem_addr;
            wdata_hold  <= mem_wdata;
            starve_cnt  <= (host_req && !host_gnt) ? starve_cnt + {7'd0, starve_cnt != 8'hFF} : 8'd0;
            state       <= (state == NORMAL)
                         ? ((host_req && !host_gnt && starve_cnt >= 8'(STARVE_LIMIT)) ? FORCE_HOST : NORMAL)
                         : ((host_gnt || !host_req) ? NORMAL : FORCE_HOST);
            tag[0]      <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
            host_rvalid <= tag[RD_LATENCY-1] == TAG_HOST;
            dsp_rvalid  <= tag[RD_LATENCY-1] == TAG_DSP;
            if (tag[RD_LATENCY-1] == TAG_HOST) host_rdata <= mem_q;
            if (tag[RD_LATENCY-1] == TAG_DSP) dsp_rdata <= mem_q;
        end
    end
endmodule

// File: tb/tb_dsp_mem_arbiter.sv
// tb_dsp_mem_arbiter: scoreboard bench for dsp_mem_arbiter with a 2-cycle registered RAM model.
module tb_dsp_mem_arbiter;
    localparam int LAT = 2;

    typedef struct {
        logic [35:0] d;
        int          t;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hreq = 1'b0, hwe = 1'b0, dreq = 1'b0;
    logic [9:0]  haddr = '0, daddr = '0;
    logic [35:0] hwdata = '0;
    logic        host_gnt, host_rvalid, dsp_gnt, dsp_rvalid, mem_wren;
    logic [35:0] host_rdata, dsp_rdata, mem_wdata, mem_q;
    logic [9:0]  mem_addr;

    logic [35:0] ram [1024];
    logic [35:0] q1, q2;
    logic [35:0] shadow [1024];
    ev_t         hq[$], dq[$], hob[$], dob[$];
    int          cyc = 0, vecs = 0, errs = 0;
    logic        g_h, g_d, s_wren;
    logic [9:0]  s_addr;
    logic [35:0] s_wdata;

    logic        p_hp = 1'b0, p_dp = 1'b0;
    logic [46:0] p_h = '0;
    logic [9:0]  p_d = '0;

    always #5 clk = ~clk;

    dsp_mem_arbiter #(.WORD_WIDTH(36), .ADDR_WIDTH(10), .RD_LATENCY(LAT), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .host_req(hreq), .host_we(hwe), .host_addr(haddr), .host_wdata(hwdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .dsp_req(dreq), .dsp_addr(daddr), .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // RAM model: new-data-on-write, address-to-q latency of LAT cycles.
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        q1 <= mem_wren ? mem_wdata : ram[mem_addr];
        q2 <= q1;
    end
    assign mem_q = q2;

    always @(posedge clk) begin
        if (!reset && p_hp && hreq && {hwe, haddr, hwdata} !== p_h) $error("host request fields changed while waiting");
        if (!reset && p_dp && dreq && daddr !== p_d) $error("dsp request address changed while waiting");
        p_hp <= hreq && !host_gnt;
        p_dp <= dreq && !dsp_gnt;
        p_h  <= {hwe, haddr, hwdata};
        p_d  <= daddr;
    end

    // Samples mid-cycle, logs returns, and pushes expectations for granted reads.
    task automatic tick();
        ev_t ev;
        @(negedge clk);
        g_h = host_gnt; g_d = dsp_gnt; s_wren = mem_wren; s_addr = mem_addr; s_wdata = mem_wdata;
        if (host_rvalid) begin ev.d = host_rdata; ev.t = cyc; hob.push_back(ev); end
        if (dsp_rvalid) begin ev.d = dsp_rdata; ev.t = cyc; dob.push_back(ev); end
        if (host_gnt && hreq && hwe) shadow[haddr] = hwdata;
        if (host_gnt && hreq && !hwe) begin ev.d = shadow[haddr]; ev.t = cyc + LAT + 1; hq.push_back(ev); end
        if (dsp_gnt && dreq) begin ev.d = shadow[daddr]; ev.t = cyc + LAT + 1; dq.push_back(ev); end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (hob.size() < hq.size() || dob.size() < dq.size()); i++) tick();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        hreq = 1'b1; dreq = 1'b1; haddr = 10'd3; daddr = 10'd4;
        tick();
        vecs++;
        if ({g_h, g_d, s_wren, host_rvalid, dsp_rvalid} !== 5'b0) begin
            errs++; $display("FAIL reset_ctl: got %b, want 00000", {g_h, g_d, s_wren, host_rvalid, dsp_rvalid});
        end
        vecs++;
        if (s_addr !== 10'd0 || s_wdata !== 36'd0) begin
            errs++; $display("FAIL reset_bus: got addr %h wdata %h, want 0/0", s_addr, s_wdata);
        end
        vecs++;
        if (host_rdata !== 36'd0 || dsp_rdata !== 36'd0) begin
            errs++; $display("FAIL reset_rdata: got %h/%h, want 0/0", host_rdata, dsp_rdata);
        end
        hreq = 1'b0; dreq = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_host_write();
        for (int i = 0; i < 16; i++) begin
            hreq = 1'b1; hwe = 1'b1; haddr = 10'(i);
            hwdata = (i == 5) ? 36'h123456789 : 36'h7_0000_0000 + 36'(i) * 36'h0_0101_0011;
            tick();
            vecs++;
            if (!g_h || !s_wren || s_addr !== haddr || s_wdata !== hwdata) begin
                errs++; $display("FAIL write_%0d: got gnt %b wren %b addr %h wdata %h, want 1 1 %h %h",
                                 i, g_h, s_wren, s_addr, s_wdata, haddr, hwdata);
            end
        end
        hreq = 1'b0; hwe = 1'b0;
        tick();
        vecs++;
        if (s_wren !== 1'b0 || s_addr !== 10'd15) begin
            errs++; $display("FAIL idle_hold: got wren %b addr %h, want 0 00f", s_wren, s_addr);
        end
    endtask

    task automatic test_host_read();
        ev_t e, o;
        hreq = 1'b1; hwe = 1'b0; haddr = 10'd5;
        tick();
        vecs++;
        if (g_h !== 1'b1 || g_d !== 1'b0) begin
            errs++; $display("FAIL host_read_gnt: got %b%b, want 10", g_h, g_d);
        end
        hreq = 1'b0;
        drain();
        vecs++;
        if (hob.size() != 1 || dob.size() != 0) begin
            errs++; $display("FAIL host_read_count: got %0d host %0d dsp, want 1 0", hob.size(), dob.size());
        end
        while (hq.size() > 0 && hob.size() > 0) begin
            e = hq.pop_front(); o = hob.pop_front();
            vecs++;
            if (o.d !== 36'h123456789 || o.t != e.t) begin
                errs++; $display("FAIL host_read_data: got %h at %0d, want 123456789 at %0d", o.d, o.t, e.t);
            end
        end
        vecs++;
        if (host_rdata !== 36'h123456789) begin
            errs++; $display("FAIL host_rdata_hold: got %h, want 123456789", host_rdata);
        end
        hq.delete(); hob.delete(); dq.delete(); dob.delete();
    endtask

    task automatic test_dsp_stream();
        ev_t e, o;
        int  gn = 0;
        for (int i = 0; i < 16; i++) begin
            dreq = 1'b1; daddr = 10'(i);
            tick();
            gn += int'(g_d);
        end
        dreq = 1'b0;
        vecs++;
        if (gn != 16) begin
            errs++; $display("FAIL dsp_stream_gnt: got %0d grants, want 16", gn);
        end
        drain();
        vecs++;
        if (dob.size() != 16 || hob.size() != 0) begin
            errs++; $display("FAIL dsp_stream_count: got %0d dsp %0d host, want 16 0", dob.size(), hob.size());
        end
        for (int i = 0; i < 16 && dq.size() > 0 && dob.size() > 0; i++) begin
            e = dq.pop_front(); o = dob.pop_front();
            vecs++;
            if (o.d !== e.d || o.t != e.t) begin
                errs++; $display("FAIL dsp_stream_%0d: got %h at %0d, want %h at %0d", i, o.d, o.t, e.d, e.t);
            end
        end
        hq.delete(); hob.delete(); dq.delete(); dob.delete();
    endtask

    task automatic test_starvation();
        ev_t e, o;
        int  at = -1;
        logic dg = 1'b1;
        dreq = 1'b1; daddr = 10'd2; hreq = 1'b1; hwe = 1'b0; haddr = 10'd5;
        for (int i = 0; i < 20 && at < 0; i++) begin
            tick();
            if (g_h) begin at = i; dg = g_d; end
        end
        hreq = 1'b0;
        vecs++;
        if (at != 9 || dg !== 1'b0) begin
            errs++; $display("FAIL starve_gnt: got host gnt at %0d dsp_gnt %b, want 9 0", at, dg);
        end
        tick();
        vecs++;
        if (g_d !== 1'b1) begin
            errs++; $display("FAIL starve_resume: got dsp_gnt %b, want 1", g_d);
        end
        repeat (2) tick();
        dreq = 1'b0;
        drain();
        vecs++;
        if (hob.size() != 1 || dob.size() != 12) begin
            errs++; $display("FAIL starve_count: got %0d host %0d dsp, want 1 12", hob.size(), dob.size());
        end
        while (hq.size() > 0 && hob.size() > 0) begin
            e = hq.pop_front(); o = hob.pop_front();
            vecs++;
            if (o.d !== e.d || o.t != e.t) begin
                errs++; $display("FAIL starve_host: got %h at %0d, want %h at %0d", o.d, o.t, e.d, e.t);
            end
        end
        while (dq.size() > 0 && dob.size() > 0) begin
            e = dq.pop_front(); o = dob.pop_front();
            vecs++;
            if (o.d !== e.d || o.t != e.t) begin
                errs++; $display("FAIL starve_dsp: got %h at %0d, want %h at %0d", o.d, o.t, e.d, e.t);
            end
        end
        hq.delete(); hob.delete(); dq.delete(); dob.delete();
    endtask

    task automatic test_interleave();
        ev_t e, o;
        for (int i = 0; i < 8; i++) begin
            hreq = (i % 2 == 0); hwe = 1'b0; haddr = 10'd3;
            dreq = (i % 2 == 1); daddr = 10'd7;
            tick();
            vecs++;
            if ({g_h, g_d} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errs++; $display("FAIL interleave_gnt_%0d: got %b%b", i, g_h, g_d);
            end
        end
        hreq = 1'b1; dreq = 1'b1;
        tick();
        vecs++;
        if ({g_h, g_d} !== 2'b01) begin
            errs++; $display("FAIL both_req_gnt: got %b%b, want 01", g_h, g_d);
        end
        dreq = 1'b0;
        tick();
        vecs++;
        if ({g_h, g_d} !== 2'b10) begin
            errs++; $display("FAIL held_host_gnt: got %b%b, want 10", g_h, g_d);
        end
        hreq = 1'b0;
        drain();
        vecs++;
        if (hob.size() != 5 || dob.size() != 5) begin
            errs++; $display("FAIL interleave_count: got %0d host %0d dsp, want 5 5", hob.size(), dob.size());
        end
        while (hq.size() > 0 && hob.size() > 0) begin
            e = hq.pop_front(); o = hob.pop_front();
            vecs++;
            if (o.d !== shadow[3] || o.t != e.t) begin
                errs++; $display("FAIL interleave_host: got %h at %0d, want %h at %0d", o.d, o.t, shadow[3], e.t);
            end
        end
        while (dq.size() > 0 && dob.size() > 0) begin
            e = dq.pop_front(); o = dob.pop_front();
            vecs++;
            if (o.d !== shadow[7] || o.t != e.t) begin
                errs++; $display("FAIL interleave_dsp: got %h at %0d, want %h at %0d", o.d, o.t, shadow[7], e.t);
            end
        end
        hq.delete(); hob.delete(); dq.delete(); dob.delete();
    endtask

    task automatic test_back_to_back();
        ev_t o;
        hreq = 1'b1; hwe = 1'b1; haddr = 10'd9; hwdata = 36'hABC;
        tick();
        hreq = 1'b0; hwe = 1'b0; dreq = 1'b1; daddr = 10'd9;
        tick();
        vecs++;
        if (g_d !== 1'b1) begin
            errs++; $display("FAIL b2b_gnt: got dsp_gnt %b, want 1", g_d);
        end
        dreq = 1'b0;
        drain();
        vecs++;
        if (dob.size() != 1 || hob.size() != 0) begin
            errs++; $display("FAIL b2b_count: got %0d dsp %0d host, want 1 0", dob.size(), hob.size());
        end
        if (dob.size() > 0) begin
            o = dob.pop_front();
            vecs++;
            if (o.d !== 36'hABC) begin
                errs++; $display("FAIL b2b_data: got %h, want abc", o.d);
            end
        end
        hq.delete(); hob.delete(); dq.delete(); dob.delete();
    endtask

    task automatic test_reset_midflight();
        ev_t e, o;
        hreq = 1'b1; hwe = 1'b0; haddr = 10'd5;
        tick();
        hreq = 1'b0; dreq = 1'b1; daddr = 10'd7;
        tick();
        vecs++;
        if (g_d !== 1'b1) begin
            errs++; $display("FAIL midflight_gnt: got dsp_gnt %b, want 1", g_d);
        end
        dreq = 1'b0; reset = 1'b1;
        hq.delete(); dq.delete();
        tick();
        vecs++;
        if ({host_gnt, dsp_gnt, mem_wren, host_rvalid, dsp_rvalid} !== 5'b0 || mem_addr !== 10'd0 ||
            mem_wdata !== 36'd0 || host_rdata !== 36'd0 || dsp_rdata !== 36'd0) begin
            errs++; $display("FAIL midflight_reset_outs: got ctl %b addr %h wdata %h rdata %h/%h, want all 0",
                             {host_gnt, dsp_gnt, mem_wren, host_rvalid, dsp_rvalid}, mem_addr, mem_wdata, host_rdata, dsp_rdata);
        end
        tick();
        reset = 1'b0;
        repeat (6) tick();
        vecs++;
        if (hob.size() != 0 || dob.size() != 0) begin
            errs++; $display("FAIL midflight_flush: got %0d host %0d dsp returns, want 0 0", hob.size(), dob.size());
        end
        hob.delete(); dob.delete();
        hreq = 1'b1; haddr = 10'd5;
        tick();
        hreq = 1'b0;
        drain();
        vecs++;
        if (hob.size() != 1 || dob.size() != 0) begin
            errs++; $display("FAIL post_reset_count: got %0d host %0d dsp, want 1 0", hob.size(), dob.size());
        end
        if (hq.size() > 0 && hob.size() > 0) begin
            e = hq.pop_front(); o = hob.pop_front();
            vecs++;
            if (o.d !== 36'h123456789 || o.t != e.t) begin
                errs++; $display("FAIL post_reset_read: got %h at %0d, want 123456789 at %0d", o.d, o.t, e.t);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_host_write();
        test_host_read();
        test_dsp_stream();
        test_starvation();
        test_interleave();
        test_back_to_back();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
